// File: rtl/conv_cfg_pkg.sv
// Shared definitions for the convolution-controller configuration master:
// register map, FSM encoding and stall limit (TOUT exists only with CFG_TIMEOUT_EN).
package conv_cfg_pkg;

  localparam int REG_CTRL      = 0;
  localparam int REG_RESET     = 4;
  localparam int REG_WIDTH     = 16;
  localparam int REG_HEIGHT    = 20;
  localparam int REG_COEF_BASE = 24;

  localparam logic [7:0] TOUT_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RESP,
    DONE
`ifdef CFG_TIMEOUT_EN
    , TOUT
`endif
  } state_t;

endpackage

// File: rtl/conv_cfg_master_seq.sv
// Combinational write-sequence table: maps the write index and the latched
// picture/coefficient values to the {address, data} pair for that write.
module conv_cfg_seq
  import conv_cfg_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int IDX_WIDTH      = 4
) (
  input  logic [IDX_WIDTH-1:0]                           index,
  input  logic [DATA_WIDTH-1:0]                          width,
  input  logic [DATA_WIDTH-1:0]                          height,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  coeff,
  output logic [AXI_ADDR_WIDTH-1:0]                      awaddr,
  output logic [DATA_WIDTH-1:0]                          wdata
);

  localparam int NCOEF = KERNEL_SIZE * KERNEL_SIZE;

  always_comb begin
    awaddr = '0;
    wdata  = '0;
    case (index)
      IDX_WIDTH'(0): begin awaddr = AXI_ADDR_WIDTH'(REG_RESET);  wdata = DATA_WIDTH'(1); end
      IDX_WIDTH'(1): begin awaddr = AXI_ADDR_WIDTH'(REG_CTRL);   wdata = DATA_WIDTH'(1); end
      IDX_WIDTH'(2): begin awaddr = AXI_ADDR_WIDTH'(REG_WIDTH);  wdata = width;          end
      IDX_WIDTH'(3): begin awaddr = AXI_ADDR_WIDTH'(REG_HEIGHT); wdata = height;         end
      default: begin
        // Coefficient writes occupy indices 4..NCOEF+3.
        for (int i = 0; i < NCOEF; i++) begin
          if (index == IDX_WIDTH'(i + 4)) begin
            awaddr = AXI_ADDR_WIDTH'(REG_COEF_BASE + 4 * i);
            wdata  = coeff[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/conv_cfg_master.sv
// Programs the convolution controller over an AXI-lite style write channel.
// Optional stall timeout (TOUT state, sticky error) is enabled by CFG_TIMEOUT_EN.
module conv_cfg_master
  import conv_cfg_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int AXI_ADDR_WIDTH = 10
) (
  input  logic                                          Clk,
  input  logic                                          Rst,
  input  logic                                          start,
  input  logic [DATA_WIDTH-1:0]                         img_width,
  input  logic [DATA_WIDTH-1:0]                         img_height,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] coeff_flat,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          error,
  output logic [AXI_ADDR_WIDTH-1:0]                     m_axi_awaddr,
  output logic                                          m_axi_awvalid,
  input  logic                                          m_axi_awready,
  output logic [DATA_WIDTH-1:0]                         m_axi_wdata,
  output logic                                          m_axi_wvalid,
  input  logic                                          m_axi_wready,
  input  logic                                          m_axi_bvalid,
  output logic                                          m_axi_bready
);

  localparam int NCOEF     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NWRITES   = NCOEF + 4;
  localparam int IDX_WIDTH = $clog2(NWRITES);
  localparam int CW        = NCOEF * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NWRITES - 1);

  state_t                      state_q, state_nxt;
  logic [IDX_WIDTH-1:0]        index_q, index_nxt;
  logic [DATA_WIDTH-1:0]       width_q, width_nxt, height_q, height_nxt;
  logic [CW-1:0]               coef_q, coef_nxt;
  logic                        awvalid_nxt, wvalid_nxt, bready_nxt, busy_nxt, done_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_nxt, seq_addr;
  logic [DATA_WIDTH-1:0]       wdata_nxt, seq_data;
  logic                        load_beat;
  logic                        aw_hs, w_hs, b_hs;
`ifdef CFG_TIMEOUT_EN
  logic [7:0]                  stall_q, stall_nxt;
  logic                        error_q, error_nxt;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;

  // Fed with next-cycle values so the beat loaded on start uses the freshly latched inputs.
  conv_cfg_seq #(
    .DATA_WIDTH    (DATA_WIDTH),
    .KERNEL_SIZE   (KERNEL_SIZE),
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_seq (
    .index (index_nxt),
    .width (width_nxt),
    .height(height_nxt),
    .coeff (coef_nxt),
    .awaddr(seq_addr),
    .wdata (seq_data)
  );

  always_comb begin
    state_nxt   = state_q;
    index_nxt   = index_q;
    width_nxt   = width_q;
    height_nxt  = height_q;
    coef_nxt    = coef_q;
    awvalid_nxt = m_axi_awvalid;
    wvalid_nxt  = m_axi_wvalid;
    bready_nxt  = m_axi_bready;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    awaddr_nxt  = m_axi_awaddr;
    wdata_nxt   = m_axi_wdata;
    load_beat   = 1'b0;
`ifdef CFG_TIMEOUT_EN
    stall_nxt   = '0;
    error_nxt   = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          width_nxt  = img_width;
          height_nxt = img_height;
          coef_nxt   = coeff_flat;
          index_nxt  = '0;
          busy_nxt   = 1'b1;
          load_beat  = 1'b1;
          state_nxt  = ISSUE;
`ifdef CFG_TIMEOUT_EN
          error_nxt  = 1'b0;
`endif
        end
      end
      ISSUE: begin
        awvalid_nxt = m_axi_awvalid && !m_axi_awready;
        wvalid_nxt  = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        if (b_hs) begin
          bready_nxt = 1'b0;
          if (index_q == LAST_IDX) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            index_nxt = index_q + IDX_WIDTH'(1);
            load_beat = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
`ifdef CFG_TIMEOUT_EN
      TOUT: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    if (load_beat) begin
      awvalid_nxt = 1'b1;
      wvalid_nxt  = 1'b1;
      awaddr_nxt  = seq_addr;
      wdata_nxt   = seq_data;
    end

`ifdef CFG_TIMEOUT_EN
    // Stall counter restarts on any handshake and whenever the state changes.
    if ((state_q == ISSUE || state_q == RESP) && !(aw_hs || w_hs || b_hs) && state_nxt == state_q) begin
      if (stall_q == TOUT_LIMIT - 8'd1) begin
        state_nxt   = TOUT;
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        error_nxt   = 1'b1;
        done_nxt    = 1'b1;
      end else begin
        stall_nxt = stall_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      index_q       <= '0;
      width_q       <= '0;
      height_q      <= '0;
      coef_q        <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      stall_q       <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_nxt;
      index_q       <= index_nxt;
      width_q       <= width_nxt;
      height_q      <= height_nxt;
      coef_q        <= coef_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_wdata   <= wdata_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
`ifdef CFG_TIMEOUT_EN
      stall_q       <= stall_nxt;
      error_q       <= error_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_conv_cfg_master.sv
// Scoreboard bench for conv_cfg_master: stimulus pushes expected writes, a
// negedge monitor pops them on each AW/W handshake. Timeout path follows CFG_TIMEOUT_EN.
module tb_conv_cfg_master;

  localparam int DW    = 8;
  localparam int KS    = 3;
  localparam int AW    = 10;
  localparam int NCOEF = KS * KS;
  localparam int NW    = NCOEF + 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              start;
  logic [DW-1:0]     img_width, img_height;
  logic [NCOEF*DW-1:0] coeff_flat;
  logic              busy, done, error;
  logic [AW-1:0]     awaddr;
  logic              awvalid, awready;
  logic [DW-1:0]     wdata;
  logic              wvalid, wready;
  logic              bvalid, bready;

  conv_cfg_master #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .AXI_ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .img_width(img_width), .img_height(img_height), .coeff_flat(coeff_flat),
    .busy(busy), .done(done), .error(error),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int aw_lens[$];
  int w_lens[$];
  int aw_count = 0;
  int w_count = 0;
  int aw_hi = 0;
  int w_hi = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  bit unstable = 0;
  bit bready_bad = 0;

  // slave controls
  int aw_delay_idx = -1;
  int aw_delay_val = 0;
  bit aw_never = 0;
  bit w_never = 0;
  bit b_force = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge Clk) begin
    if (Rst) begin
      aw_hi = 0;
      w_hi = 0;
    end else begin
      if (awvalid) begin
        if (aw_hi > 0 && awaddr !== prev_addr) unstable = 1;
        prev_addr = awaddr;
        aw_hi++;
        if (awready) begin
          aw_count++;
          aw_lens.push_back(aw_hi);
          aw_hi = 0;
          if (exp_addr_q.size() == 0) check("aw_pending", exp_addr_q.size(), 1);
          else check("awaddr", int'(awaddr), int'(exp_addr_q.pop_front()));
        end
      end
      if (wvalid) begin
        if (w_hi > 0 && wdata !== prev_data) unstable = 1;
        prev_data = wdata;
        w_hi++;
        if (wready) begin
          w_count++;
          w_lens.push_back(w_hi);
          w_hi = 0;
          if (exp_data_q.size() == 0) check("w_pending", exp_data_q.size(), 1);
          else check("wdata", int'(wdata), int'(exp_data_q.pop_front()));
        end
      end
      if ((awvalid || wvalid) && bready) bready_bad = 1;
    end
  end

  // Slave model: ready when valid seen, B one cycle after W handshake.
  initial begin
    int aw_wait;
    bit w_hs_s, b_hs_s, rst_s, b_pend;
    aw_wait = 0;
    b_pend = 0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    forever begin
      @(negedge Clk);
      rst_s  = (Rst === 1'b1);
      w_hs_s = (wvalid === 1'b1) && (wready === 1'b1);
      b_hs_s = (bvalid === 1'b1) && (bready === 1'b1);
      @(posedge Clk);
      #1;
      if (rst_s) b_pend = 0;
      else begin
        if (b_hs_s) b_pend = 0;
        if (w_hs_s) b_pend = 1;
      end
      bvalid = b_pend || b_force;
      if (awvalid === 1'b1 && !aw_never) begin
        awready = (aw_count == aw_delay_idx) ? (aw_wait >= aw_delay_val) : 1'b1;
        aw_wait++;
      end else begin
        awready = 1'b0;
        if (awvalid !== 1'b1) aw_wait = 0;
      end
      wready = (wvalid === 1'b1) && !w_never;
    end
  end

  task automatic push_exp(input logic [DW-1:0] w, input logic [DW-1:0] h);
    logic [AW-1:0] a;
    exp_addr_q.push_back(AW'(4));  exp_data_q.push_back(DW'(1));
    exp_addr_q.push_back(AW'(0));  exp_data_q.push_back(DW'(1));
    exp_addr_q.push_back(AW'(16)); exp_data_q.push_back(w);
    exp_addr_q.push_back(AW'(20)); exp_data_q.push_back(h);
    for (int i = 0; i < NCOEF; i++) begin
      a = AW'(24 + 4 * i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(DW'(i));
    end
  endtask

  task automatic clear_stats();
    aw_count = 0;
    w_count = 0;
    aw_lens.delete();
    w_lens.delete();
    unstable = 0;
    bready_bad = 0;
  endtask

  // Returns the edge number on which start is sampled; leaves us at posedge+1 of that edge.
  task automatic pulse_start(output int sedge);
    @(posedge Clk); #1;
    start = 1'b1;
    sedge = cyc + 1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int sedge, input int exp_off, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge Clk);
      if (done) seen = 1;
    end
    if (!seen) check({tag, "_done_seen"}, 0, 1);
    else begin
      check({tag, "_done_cycle"}, cyc - sedge, exp_off);
      @(negedge Clk);
      check({tag, "_done_pulse"}, int'(done), 0);
      check({tag, "_busy_after"}, int'(busy), 0);
    end
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    int s;
    bit saw_done;
    Rst = 1'b1;
    start = 1'b0;
    img_width = 8'd5;
    img_height = 8'd5;
    for (int i = 0; i < NCOEF; i++) coeff_flat[i*DW +: DW] = DW'(i);
    repeat (3) @(posedge Clk);
    #1;
    check("reset_outputs", int'({awvalid, wvalid, bready, busy, done, error}), 0);
    check("reset_awaddr", int'(awaddr), 0);
    check("reset_wdata", int'(wdata), 0);
    Rst = 1'b0;

    // Nominal sequence
    clear_stats();
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    check("t1_busy_after_start", int'(busy), 1);
    wait_done(s, 26, "t1");
    check("t1_write_count", aw_count, NW);
    check("t1_w_count", w_count, NW);

    // Delayed awready on write 2
    clear_stats();
    aw_delay_idx = 2;
    aw_delay_val = 3;
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    wait_done(s, 29, "t2");
    aw_delay_idx = -1;
    check("t2_write_count", aw_count, NW);
    check("t2_aw_len", (aw_lens.size() > 2) ? aw_lens[2] : -1, 4);
    check("t2_w_len", (w_lens.size() > 2) ? w_lens[2] : -1, 1);
    check("t2_stable", int'(unstable), 0);

    // Restart attempt and input change mid-sequence
    clear_stats();
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    repeat (4) @(posedge Clk);
    #1;
    start = 1'b1;
    img_width = 8'd9;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_done(s, 26, "t3");
    check("t3_write_count", aw_count, NW);
    img_width = 8'd5;

    // Reset in RESP of write 7
    clear_stats();
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(posedge Clk); #1;
        if (aw_count >= 8 && bready) hit = 1;
      end
      check("t4_reached_resp7", int'(hit), 1);
    end
    Rst = 1'b1;
    @(posedge Clk); #1;
    check("t4_outputs_cleared", int'({awvalid, wvalid, bready, busy, done, error}), 0);
    check("t4_addr_data_cleared", int'({awaddr, wdata}), 0);
    Rst = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    clear_stats();
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    check("t4_restart_addr", int'(awaddr), 4);
    wait_done(s, 26, "t4");
    check("t4_write_count", aw_count, NW);

    // bvalid held high throughout
    clear_stats();
    b_force = 1;
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    wait_done(s, 26, "t5");
    b_force = 0;
    check("t5_bready_in_issue", int'(bready_bad), 0);
    check("t5_write_count", aw_count, NW);
    @(posedge Clk); #1;

    // Stalled slave
    clear_stats();
    aw_never = 1;
    w_never = 1;
`ifdef CFG_TIMEOUT_EN
    pulse_start(s);
    wait_done(s, 255, "t6");
    check("t6_error_sticky", int'(error), 1);
    aw_never = 0;
    w_never = 0;
    clear_stats();
    push_exp(8'd5, 8'd5);
    pulse_start(s);
    check("t6_error_cleared", int'(error), 0);
    wait_done(s, 26, "t6b");
`else
    saw_done = 0;
    pulse_start(s);
    repeat (300) begin
      @(negedge Clk);
      if (done) saw_done = 1;
    end
    check("t6_busy_held", int'(busy), 1);
    check("t6_error_zero", int'(error), 0);
    check("t6_no_done", int'(saw_done), 0);
    aw_never = 0;
    w_never = 0;
    do_reset();
`endif
    check("final_queue_empty", exp_addr_q.size() + exp_data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_cfg_master.md
CONV_CFG_MASTER -- requirements
Module: conv_cfg_master

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, width of every register write and coefficient.
REQ-002 SHALL have parameter KERNEL_SIZE, 3, kernel side length; NCOEF = KERNEL_SIZE*KERNEL_SIZE.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, 10, width of the write address.
REQ-004 SHALL have one clock and a synchronous active-high reset, with these ports:
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  begin a programming sequence.
- img_width  in  DATA_WIDTH  picture width.
- img_height  in  DATA_WIDTH  picture height.
- coeff_flat  in  NCOEF*DATA_WIDTH  coefficient i at [i*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag.
- m_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  address valid.
- m_axi_awready  in  1  address accepted.
- m_axi_wdata  out  DATA_WIDTH  write data.
- m_axi_wvalid  out  1  data valid.
- m_axi_wready  in  1  data accepted.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  response accepted.

Function
REQ-005 SHALL write the convolution controller's control port in this fixed order (addr/data):
- 4/1 (soft reset)
- 0/1 (enable)
- 16/img_width
- 20/img_height
- 24+4i/coeff i, for i=0..NCOEF-1
This is NCOEF+4 writes (13 at defaults).
REQ-006 SHALL latch img_width, img_height and coeff_flat on the edge where start is accepted in IDLE; later input changes do not affect the sequence.
REQ-007 SHALL ignore start while busy=1.
REQ-008 SHALL have states IDLE, ISSUE, RESP, DONE, and TOUT when CFG_TIMEOUT_EN is defined.
REQ-009 Transitions:
- IDLE->ISSUE on start.
- ISSUE->RESP once both AW and W have handshaken.
- RESP->ISSUE on bvalid&&bready when writes remain.
- RESP->DONE on the final B handshake.
- DONE->IDLE unconditionally.
REQ-010 In ISSUE, awvalid and wvalid SHALL assert together in the first cycle.
- Each drops on the edge after its own ready is sampled high.
- The two channels may complete in different cycles.
- Address and data SHALL stay stable while the corresponding valid is high.
REQ-011 bready SHALL be high only in RESP; bvalid in any other state SHALL be ignored.
REQ-012 All outputs SHALL be registered. With an always-ready slave that answers bvalid in the cycle after W, each write costs 2 cycles. done SHALL rise 2*(NCOEF+4) cycles after the start edge (26 at defaults).
REQ-013 busy SHALL be high from the cycle after start acceptance through the DONE cycle inclusive. done SHALL be high only in DONE.
REQ-014 The write index SHALL run 0..NCOEF+3 with no wrap. At the last index the transition goes to DONE, never back to ISSUE.

Reset
REQ-015 On Rst=1 at a rising edge, regardless of state:
- state=IDLE, index=0.
- awvalid=wvalid=bready=0, busy=done=error=0.
- awaddr=0, wdata=0.
REQ-016 Reset mid-transaction SHALL drop all valids on that edge. No partial write SHALL be retried afterwards.

Configuration
REQ-017 Macro CFG_TIMEOUT_EN:
- When defined, an 8-bit stall counter runs in ISSUE and RESP. It clears on any handshake and on each state entry.
- At 255 stalled cycles the block SHALL go to TOUT: drop all valids/bready, set error=1, pulse done for one cycle, then return to IDLE.
- error clears only on Rst or on the next accepted start.
REQ-018 When CFG_TIMEOUT_EN is undefined, SHALL have no counter and no TOUT state, error SHALL tie to 0, and the block SHALL wait indefinitely.

Structure
REQ-019 Shared package conv_cfg_pkg SHALL hold:
- Register offsets: REG_CTRL=0, REG_RESET=4, REG_WIDTH=16, REG_HEIGHT=20, REG_COEF_BASE=24.
- The state-encoding typedef.
- The timeout limit constant (255).
REQ-020 One sub-module, conv_cfg_seq, SHALL be purely combinational: it maps index plus latched values to {awaddr, wdata}. The FSM stays in conv_cfg_master.

Verification
REQ-021 Always-ready slave with 1-cycle bvalid; width=5, height=5, coeff i=i; pulse start -> 13 writes in REQ-005 order; done at cycle 26; busy low after.
REQ-022 awready delayed 3 cycles and wready immediate on write 2 -> wvalid drops after 1 cycle, awvalid holds 3, addr/data stable, single write counted.
REQ-023 start re-pulsed at cycle 5 and img_width changed to 9 mid-sequence -> ignored, width write still carries 5.
REQ-024 Rst asserted in RESP of write 7 -> all outputs 0 next edge; new start restarts at addr 4.
REQ-025 bvalid held high while in ISSUE -> no early index advance; bready low until RESP.
REQ-026 With CFG_TIMEOUT_EN, slave never asserts awready -> error=1 and done pulse 255 cycles after ISSUE entry; without the macro -> busy stays high, error=0.
